// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared types for the ALU arbiter
package alu_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} arb_state_t;
endpackage

// File: rtl/alu_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker, first request above the last grant wins
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               any
);
  logic [ID_W-1:0] idx;
  always_comb begin
    gnt_id = '0;
    idx = '0;
    any = |req;
    // scan from farthest to nearest so the closest candidate after last is written last
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = ID_W'((int'(last) + k) % NUM_REQ);
      if (req[idx]) gnt_id = idx;
    end
    gnt = any ? NUM_REQ'(1) << gnt_id : '0;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU with a tagged response channel
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [5*NUM_REQ-1:0]  req_opt,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [4:0]            alu_opt,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  input  logic [31:0]           alu_out,
  input  logic                  alu_zero,
  input  logic                  alu_negative,
  input  logic                  alu_carry,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [31:0]           rsp_out,
  output logic                  rsp_zero,
  output logic                  rsp_negative,
  output logic                  rsp_carry
);
  arb_state_t state, state_nx;
  logic [ID_W-1:0] last_grant, gnt_id, id_q;
  logic [NUM_REQ-1:0] gnt;
  logic any, accept, hs;
  logic [4:0] opt_arr [NUM_REQ];
  logic [31:0] a_arr [NUM_REQ];
  logic [31:0] b_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign opt_arr[i] = req_opt[5*i +: 5];
    assign a_arr[i] = req_a[32*i +: 32];
    assign b_arr[i] = req_b[32*i +: 32];
  end
  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .req(req_valid),
    .last(last_grant),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .any(any)
  );
  always_comb begin
    accept = !reset && (state == IDLE || (state == HOLD && rsp_ready));
    hs = accept && any;
    req_ready = hs ? gnt : '0;
    state_nx = state == EXEC ? HOLD : hs ? EXEC : (state == HOLD && !rsp_ready) ? HOLD : IDLE;
  end
  assign rsp_valid = state == HOLD;
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= ID_W'(NUM_REQ - 1);
      id_q <= '0;
      alu_opt <= '0;
      alu_a <= '0;
      alu_b <= '0;
      rsp_id <= '0;
      rsp_out <= '0;
      rsp_zero <= 1'b0;
      rsp_negative <= 1'b0;
      rsp_carry <= 1'b0;
    end else begin
      if (hs) begin
        last_grant <= gnt_id;
        id_q <= gnt_id;
        alu_opt <= opt_arr[gnt_id];
        alu_a <= a_arr[gnt_id];
        alu_b <= b_arr[gnt_id];
      end
      if (state == EXEC) begin
        rsp_id <= id_q;
        rsp_out <= alu_out;
        rsp_zero <= alu_zero;
        rsp_negative <= alu_negative;
        rsp_carry <= alu_carry;
      end
    end
  end
endmodule
